// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage. Owns PCF, drives the instruction
// memory handshake, loads the IF/ID register and parks branch redirects
// that arrive while an access is still outstanding.
module fetch_stage #(
   parameter int              SIZE     = 32,
   parameter logic [SIZE-1:0] RESET_PC = '0,
   parameter logic [SIZE-1:0] NOP      = SIZE'(32'h0000_0013)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stallf,
   input  logic            stallD,
   input  logic            flushD,
   input  logic            pc_sel,
   input  logic [SIZE-1:0] pc_target,
   output logic            imem_req,
   output logic [SIZE-1:0] imem_addr,
   input  logic [SIZE-1:0] imem_rdata,
   input  logic            imem_ready,
   output logic [SIZE-1:0] instrD,
   output logic [SIZE-1:0] pcD,
   output logic [SIZE-1:0] pc4D,
   output logic            validD,
   output logic            fetch_busy
);

   localparam logic [1:0] ST_RST   = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_REDIR = 2'd2;

   logic [1:0]      state;
   logic [SIZE-1:0] pcf;
   logic [SIZE-1:0] pend_pc;
   logic [SIZE-1:0] pcf_plus4;
   logic            load_ifid;

   // PC+4 wraps silently at the top of the address space
   assign pcf_plus4 = pcf + SIZE'(4);

   // imem_addr comes straight from PCF, so it cannot move mid-access and
   // has no path from stallf/pc_sel
   assign imem_req   = (state != ST_RST);
   assign imem_addr  = pcf;
   assign fetch_busy = ((state == ST_FETCH) && !imem_ready) || (state == ST_REDIR);

   // only a clean, completed, unredirected, unstalled fetch reaches decode
   assign load_ifid = (state == ST_FETCH) && imem_ready && !pc_sel && !stallf;

   // fetch FSM and PC update
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= ST_RST;
         pcf     <= RESET_PC;
         pend_pc <= '0;
      end else begin
         case (state)
            // one idle cycle after reset; a stray pc_sel here is ignored
            ST_RST: state <= ST_FETCH;
            ST_FETCH: begin
               if (pc_sel && imem_ready) begin
                  pcf <= pc_target;
               end else if (pc_sel) begin
                  // access still in flight: park the target, keep addr stable
                  pend_pc <= pc_target;
                  state   <= ST_REDIR;
               end else if (stallf) begin
                  pcf <= pcf;
               end else if (imem_ready) begin
                  pcf <= pcf_plus4;
               end
            end
            ST_REDIR: begin
               if (imem_ready) begin
                  // stale response is dropped; newest target wins
                  pcf   <= pc_sel ? pc_target : pend_pc;
                  state <= ST_FETCH;
               end else if (pc_sel) begin
                  pend_pc <= pc_target;
               end
            end
            default: state <= ST_RST;
         endcase
      end
   end

   // IF/ID register: reset > flush > stall > load > bubble
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         instrD <= NOP;
         pcD    <= '0;
         pc4D   <= '0;
         validD <= 1'b0;
      end else if (flushD) begin
         instrD <= NOP;
         validD <= 1'b0;
      end else if (stallD) begin
         instrD <= instrD;
         validD <= validD;
      end else if (load_ifid) begin
         instrD <= imem_rdata;
         pcD    <= pcf;
         pc4D   <= pcf_plus4;
         validD <= 1'b1;
      end else begin
         instrD <= NOP;
         validD <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vectors; the stimulus pushes expected port values
// for the current cycle and expected IF/ID contents for the next cycle into a
// scoreboard, and a negedge monitor pops and compares them.
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stallf, stallD, flushD, pc_sel;
   logic [31:0] pc_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ready;
   logic [31:0] instrD, pcD, pc4D;
   logic        validD, fetch_busy;

   int checks   = 0;
   int failures = 0;
   int cycle    = 0;
   bit end_chk  = 0;

   typedef struct {
      int          cyc;
      bit          is_id;
      logic        ereq;
      logic        ebusy;
      logic [31:0] eaddr;
      logic        evalid;
      logic [31:0] epc;
      bit          cmp_pc;
   } exp_t;

   exp_t sbq[$];

   fetch_stage #(.SIZE(32), .RESET_PC(32'h0), .NOP(NOP)) dut (
      .clk(clk), .rst_n(rst_n), .stallf(stallf), .stallD(stallD),
      .flushD(flushD), .pc_sel(pc_sel), .pc_target(pc_target),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .imem_ready(imem_ready), .instrD(instrD), .pcD(pcD), .pc4D(pc4D),
      .validD(validD), .fetch_busy(fetch_busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   // memory word is a distinct function of the address
   function automatic logic [31:0] word(input logic [31:0] a);
      return {~a[15:0], a[15:0]};
   endfunction

   assign imem_rdata = imem_ready ? word(imem_addr) : 32'hBAD0_BAD0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%h expected=%h", name, cycle, act, exp);
      end
   endtask

   // monitor: compare every scoreboard entry due this cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         while (sbq.size() > 0 && sbq[0].cyc <= cycle) begin
            e = sbq.pop_front();
            chk("sb_stamp", 32'(e.cyc), 32'(cycle));
            if (e.is_id) begin
               chk("validD", {31'b0, validD}, {31'b0, e.evalid});
               chk("instrD", instrD, e.evalid ? word(e.epc) : NOP);
               if (e.cmp_pc) begin
                  chk("pcD", pcD, e.epc);
                  chk("pc4D", pc4D, e.evalid ? e.epc + 32'd4 : 32'h0);
               end
            end else begin
               chk("imem_req", {31'b0, imem_req}, {31'b0, e.ereq});
               chk("fetch_busy", {31'b0, fetch_busy}, {31'b0, e.ebusy});
               chk("imem_addr", imem_addr, e.eaddr);
            end
         end
         if (end_chk) chk("sb_drain", 32'(sbq.size()), 32'h0);
      end
   end

   task automatic push_port(input int c, input logic rq, input logic bz, input logic [31:0] a);
      exp_t e;
      e = '{cyc: c, is_id: 0, ereq: rq, ebusy: bz, eaddr: a, evalid: 0, epc: 0, cmp_pc: 0};
      sbq.push_back(e);
   endtask

   task automatic push_id(input int c, input logic v, input logic [31:0] p, input bit cp);
      exp_t e;
      e = '{cyc: c, is_id: 1, ereq: 0, ebusy: 0, eaddr: 0, evalid: v, epc: p, cmp_pc: cp};
      sbq.push_back(e);
   endtask

   // one cycle: drive inputs, expect ports now and IF/ID contents next cycle
   task automatic cyc(input logic rdy, input logic sf, input logic sd, input logic fd,
                      input logic ps, input logic [31:0] tgt,
                      input logic ereq, input logic ebusy, input logic [31:0] eaddr,
                      input logic nv, input logic [31:0] npc, input bit ncmp);
      imem_ready = rdy; stallf = sf; stallD = sd; flushD = fd;
      pc_sel = ps; pc_target = tgt;
      push_port(cycle, ereq, ebusy, eaddr);
      push_id(cycle + 1, nv, npc, ncmp | nv);
      @(posedge clk); #1;
   endtask

   initial begin
      rst_n = 1'b0; stallf = 0; stallD = 0; flushD = 0; pc_sel = 0;
      pc_target = '0; imem_ready = 0;
      @(posedge clk); #1;
      // reset state
      push_port(cycle, 1'b0, 1'b0, 32'h0);
      push_id(cycle, 1'b0, 32'h0, 1'b1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      //  rdy sf sd fd ps target         req bsy addr           nv npc           cmp
      cyc(1, 0, 0, 0, 1, 32'h999,      0, 0, 32'h0,         0, 32'h0,        0); // RST ignores pc_sel
      cyc(1, 0, 0, 0, 0, 32'h0,        1, 0, 32'h0,         1, 32'h0,        0);
      cyc(1, 0, 0, 0, 0, 32'h0,        1, 0, 32'h4,         1, 32'h4,        0);
      cyc(1, 0, 0, 0, 0, 32'h0,        1, 0, 32'h8,         1, 32'h8,        0);
      cyc(1, 0, 0, 0, 0, 32'h0,        1, 0, 32'hC,         1, 32'hC,        0);
      cyc(0, 0, 0, 0, 0, 32'h0,        1, 1, 32'h10,        0, 32'h0,        0); // wait states
      cyc(0, 0, 0, 0, 0, 32'h0,        1, 1, 32'h10,        0, 32'h0,        0);
      cyc(0, 0, 0, 0, 0, 32'h0,        1, 1, 32'h10,        0, 32'h0,        0);
      cyc(1, 0, 0, 0, 0, 32'h0,        1, 0, 32'h10,        1, 32'h10,       0);
      cyc(1, 1, 1, 0, 0, 32'h0,        1, 0, 32'h14,        1, 32'h10,       0); // load-use stall
      cyc(1, 0, 0, 0, 0, 32'h0,        1, 0, 32'h14,        1, 32'h14,       0);
      cyc(1, 0, 0, 0, 0, 32'h0,        1, 0, 32'h18,        1, 32'h18,       0);
      cyc(1, 0, 0, 1, 1, 32'h100,      1, 0, 32'h1C,        0, 32'h0,        0); // redirect hit
      cyc(1, 0, 0, 0, 0, 32'h0,        1, 0, 32'h100,       1, 32'h100,      0);
      cyc(0, 0, 0, 0, 1, 32'h200,      1, 1, 32'h104,       0, 32'h0,        0); // redirect in wait
      cyc(0, 0, 0, 0, 1, 32'h300,      1, 1, 32'h104,       0, 32'h0,        0);
      cyc(1, 0, 0, 0, 0, 32'h0,        1, 1, 32'h104,       0, 32'h0,        0);
      cyc(1, 0, 0, 0, 0, 32'h0,        1, 0, 32'h300,       1, 32'h300,      0);
      cyc(0, 0, 0, 0, 1, 32'h400,      1, 1, 32'h304,       0, 32'h0,        0);
      cyc(1, 0, 0, 0, 1, 32'h500,      1, 1, 32'h304,       0, 32'h0,        0); // same-cycle target
      cyc(1, 0, 0, 0, 0, 32'h0,        1, 0, 32'h500,       1, 32'h500,      0);
      cyc(1, 0, 1, 1, 0, 32'h0,        1, 0, 32'h504,       0, 32'h0,        0); // flush beats stall
      cyc(1, 0, 0, 0, 1, 32'hFFFF_FFFC, 1, 0, 32'h508,      0, 32'h0,        0);
      cyc(1, 0, 0, 0, 0, 32'h0,        1, 0, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0); // wrap
      cyc(1, 0, 0, 0, 0, 32'h0,        1, 0, 32'h0,         1, 32'h0,        0);
      cyc(0, 0, 0, 0, 0, 32'h0,        1, 1, 32'h4,         0, 32'h0,        0);
      rst_n = 1'b0;                                                              // mid-access reset
      cyc(0, 0, 0, 0, 0, 32'h0,        1, 1, 32'h4,         0, 32'h0,        1);
      rst_n = 1'b1;
      cyc(1, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,         0, 32'h0,        0);
      cyc(1, 0, 0, 0, 0, 32'h0,        1, 0, 32'h0,         1, 32'h0,        0);
      cyc(1, 0, 0, 0, 0, 32'h0,        1, 0, 32'h4,         1, 32'h4,        0);
      cyc(0, 0, 0, 0, 0, 32'h0,        1, 1, 32'h8,         0, 32'h0,        0);
      repeat (2) @(posedge clk);
      #1 end_chk = 1'b1;
      @(posedge clk); #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
